ysyx_22041211_lsu: RTL and testbench
====================================

// Module: ysyx_22041211_lsu
// PURPOSE
//  Load/store unit between EXU and WB in the multi-cycle core. Accepts one EXU result per
//  valid/ready handshake, runs any load/store over a word-wide req/gnt/rvalid memory bus with
//  byte strobes, aligns and extends load data, and hands a finished result to WB.
//  Non-memory results pass through in one cycle; misaligned accesses complete without a bus access.
// PARAMETERS
//  DATA_LEN  32  datapath/address width (only 32 supported)
// PORTS
//  clk           in   1   clock
//  rst           in   1   reset, synchronous, active-high
//  exu_valid_i   in   1   EXU result valid
//  lsu_ready_o   out  1   LSU can accept (state IDLE)
//  load_type_i   in   3   0=none, LOAD_LB_8/LOAD_LH_16/LOAD_LW_32/LOAD_LBU_8/LOAD_LHU_16 (define header)
//  store_type_i  in   2   0=none, STORE_SB_8/STORE_SH_16/STORE_SW_32
//  alu_result_i  in   32  effective address (mem op) or result (non-mem)
//  store_data_i  in   32  store data, low-aligned
//  wd_i / wreg_i in   1/5 GPR write enable / index
//  csr_wdata_i   in   32  CSR write data, passed through
//  mem_req_o     out  1   bus request
//  mem_we_o      out  1   1=write
//  mem_addr_o    out  32  word address {addr[31:2],2'b00}
//  mem_wdata_o   out  32  lane-replicated store data
//  mem_wstrb_o   out  4   byte strobes (0 on reads)
//  mem_gnt_i     in   1   request accepted
//  mem_rvalid_i  in   1   read data / write ack valid
//  mem_rdata_i   in   32  read word
//  lsu_valid_o   out  1   result valid to WB
//  wb_ready_i    in   1   WB accepts
//  wd_o/wreg_o   out  1/5 GPR write enable / index
//  wdata_o       out  32  load data or passthrough result
//  csr_wdata_o   out  32  registered csr_wdata_i
//  misalign_o    out  1   access was misaligned
// BEHAVIOUR
//  - Reset: state IDLE; lsu_valid_o, mem_req_o, mem_we_o, wd_o, misalign_o = 0; mem_wstrb_o=0;
//    wreg_o, wdata_o, csr_wdata_o, mem_addr_o, mem_wdata_o = 0. Reset mid-transaction drops the
//    request and abandons any outstanding rvalid (rvalid in IDLE is ignored).
//  - Accept when exu_valid_i & lsu_ready_o; all inputs captured that edge; EXU need not hold them.
//  - Misaligned: LH/LHU/SH with addr[0]=1; LW/SW with addr[1:0]!=0. Goes IDLE->RESP, no bus
//    access, misalign_o=1, wd_o=0. load_type and store_type both nonzero: load wins.
//  - FSM: IDLE -> ADDR (aligned load/store) | RESP (non-mem or misaligned).
//    ADDR: mem_req_o=1, addr/we/wdata/wstrb stable until mem_gnt_i; on gnt -> DATA, req drops.
//    DATA: wait mem_rvalid_i (writes wait for ack too); rvalid sampled only in DATA; on rvalid
//      capture wdata_o -> RESP. rvalid same cycle as gnt is not legal for the slave.
//    RESP: lsu_valid_o=1, outputs stable until wb_ready_i; then -> IDLE.
//  - Latency: non-mem accept->lsu_valid_o 1 cycle; zero-wait bus (gnt same cycle as req, rvalid
//    next cycle) 3 cycles; throughput one op per (latency+1) minimum.
//  - Stores: wstrb SB=4'b0001<<a, SH=4'b0011<<a, SW=4'b1111 (a=addr[1:0]); wdata_o=0, wd_o=wd_i.
//  - Loads: w = mem_rdata_i >> (8*a); LB/LH sign-extend w[7:0]/w[15:0]; LBU/LHU zero-extend; LW = w.
//  - Non-mem: wdata_o=alu_result_i, wd_o=wd_i. csr_wdata_o, wreg_o always registered at accept.
// TESTING
//  - Non-mem: alu_result_i=0x1234, wd_i=1, wreg=5, wb_ready_i=1 -> lsu_valid_o next cycle, wdata_o=0x1234.
//  - LB addr 0x80000003, rdata 0x80FF_0000 -> req addr 0x80000000, wstrb 0, wdata_o=0xFFFFFF80.
//  - SH addr 0x80000002 data 0xABCD -> wstrb 4'b1100, mem_wdata_o=0xABCDABCD, done after rvalid.
//  - LW addr 0x80000006 -> no mem_req_o, misalign_o=1, wd_o=0, lsu_valid_o 1 cycle after accept.
//  - gnt stalled 3 cycles, wb_ready_i low 2 cycles -> addr/strb and results held stable; ready low.
//  - rst asserted in DATA, late rvalid after -> state IDLE, lsu_valid_o=0, rvalid ignored.

Source files
------------

// File: rtl/ysyx_22041211_lsu_if.sv
// rtl/ysyx_22041211_lsu_if.sv - word-wide req/gnt/rvalid memory bus between LSU and memory
interface ysyx_22041211_lsu_if;
  logic        mem_req;
  logic        mem_we;
  logic [31:0] mem_addr;
  logic [31:0] mem_wdata;
  logic [3:0]  mem_wstrb;
  logic        mem_gnt;
  logic        mem_rvalid;
  logic [31:0] mem_rdata;

  modport master (
    output mem_req, mem_we, mem_addr, mem_wdata, mem_wstrb,
    input  mem_gnt, mem_rvalid, mem_rdata
  );

  modport slave (
    input  mem_req, mem_we, mem_addr, mem_wdata, mem_wstrb,
    output mem_gnt, mem_rvalid, mem_rdata
  );
endinterface

// File: rtl/ysyx_22041211_lsu.sv
// rtl/ysyx_22041211_lsu.sv - load/store unit between EXU and WB with aligned bus access and load extension
module ysyx_22041211_lsu #(
  parameter int DATA_LEN = 32
) (
  input  logic                clk,
  input  logic                rst,
  input  logic                exu_valid_i,
  output logic                lsu_ready_o,
  input  logic [2:0]          load_type_i,
  input  logic [1:0]          store_type_i,
  input  logic [DATA_LEN-1:0] alu_result_i,
  input  logic [DATA_LEN-1:0] store_data_i,
  input  logic                wd_i,
  input  logic [4:0]          wreg_i,
  input  logic [DATA_LEN-1:0] csr_wdata_i,
  ysyx_22041211_lsu_if.master mem,
  output logic                lsu_valid_o,
  input  logic                wb_ready_i,
  output logic                wd_o,
  output logic [4:0]          wreg_o,
  output logic [DATA_LEN-1:0] wdata_o,
  output logic [DATA_LEN-1:0] csr_wdata_o,
  output logic                misalign_o
);
  localparam logic [2:0] LOAD_LB_8   = 3'd1;
  localparam logic [2:0] LOAD_LH_16  = 3'd2;
  localparam logic [2:0] LOAD_LW_32  = 3'd3;
  localparam logic [2:0] LOAD_LBU_8  = 3'd4;
  localparam logic [2:0] LOAD_LHU_16 = 3'd5;
  localparam logic [1:0] STORE_SB_8  = 2'd1;
  localparam logic [1:0] STORE_SH_16 = 2'd2;
  localparam logic [1:0] STORE_SW_32 = 2'd3;

  typedef enum logic [1:0] {IDLE, ADDR, DATA, RESP} state_t;

  state_t      state_q, state_d;
  logic [2:0]  ld_type_q;
  logic [1:0]  off_q;
  logic        we_q;
  logic [31:0] addr_q, mwdata_q;
  logic [3:0]  strb_q;

  logic        is_load, is_store, acc_misalign;
  logic [3:0]  acc_strb;
  logic [31:0] acc_mwdata, shifted, load_val;

  // A load request takes priority when EXU flags both a load and a store.
  assign is_load  = (load_type_i != 3'd0);
  assign is_store = !is_load && (store_type_i != 2'd0);

  always_comb begin
    acc_misalign = 1'b0;
    acc_strb     = 4'b0000;
    acc_mwdata   = store_data_i;
    if (is_load) begin
      case (load_type_i)
        LOAD_LH_16, LOAD_LHU_16: acc_misalign = alu_result_i[0];
        LOAD_LW_32:              acc_misalign = (alu_result_i[1:0] != 2'b00);
        default:                 acc_misalign = 1'b0;
      endcase
    end else if (is_store) begin
      case (store_type_i)
        STORE_SB_8: begin
          acc_strb   = 4'b0001 << alu_result_i[1:0];
          acc_mwdata = {4{store_data_i[7:0]}};
        end
        STORE_SH_16: begin
          acc_misalign = alu_result_i[0];
          acc_strb     = 4'b0011 << alu_result_i[1:0];
          acc_mwdata   = {2{store_data_i[15:0]}};
        end
        STORE_SW_32: begin
          acc_misalign = (alu_result_i[1:0] != 2'b00);
          acc_strb     = 4'b1111;
        end
        default: acc_strb = 4'b0000;
      endcase
    end
  end

  always_comb begin
    shifted  = mem.mem_rdata >> {off_q, 3'b000};
    load_val = shifted;
    case (ld_type_q)
      LOAD_LB_8:   load_val = {{24{shifted[7]}}, shifted[7:0]};
      LOAD_LH_16:  load_val = {{16{shifted[15]}}, shifted[15:0]};
      LOAD_LBU_8:  load_val = {24'd0, shifted[7:0]};
      LOAD_LHU_16: load_val = {16'd0, shifted[15:0]};
      default:     load_val = shifted;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) state_q <= IDLE;
    else     state_q <= state_d;
  end

  always_comb begin
    state_d = state_q;
    case (state_q)
      IDLE: if (exu_valid_i) state_d = ((is_load || is_store) && !acc_misalign) ? ADDR : RESP;
      ADDR: if (mem.mem_gnt) state_d = DATA;
      DATA: if (mem.mem_rvalid) state_d = RESP;
      RESP: if (wb_ready_i) state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      ld_type_q   <= 3'd0;
      off_q       <= 2'd0;
      we_q        <= 1'b0;
      addr_q      <= 32'd0;
      mwdata_q    <= 32'd0;
      strb_q      <= 4'd0;
      wd_o        <= 1'b0;
      wreg_o      <= 5'd0;
      wdata_o     <= 32'd0;
      csr_wdata_o <= 32'd0;
      misalign_o  <= 1'b0;
    end else begin
      case (state_q)
        IDLE: if (exu_valid_i) begin
          wreg_o      <= wreg_i;
          csr_wdata_o <= csr_wdata_i;
          misalign_o  <= acc_misalign;
          wd_o        <= wd_i & ~acc_misalign;
          wdata_o     <= (is_load || is_store) ? 32'd0 : alu_result_i;
          ld_type_q   <= is_load ? load_type_i : 3'd0;
          off_q       <= alu_result_i[1:0];
          if ((is_load || is_store) && !acc_misalign) begin
            addr_q   <= {alu_result_i[31:2], 2'b00};
            we_q     <= is_store;
            mwdata_q <= acc_mwdata;
            strb_q   <= acc_strb;
          end
        end
        DATA: if (mem.mem_rvalid && ld_type_q != 3'd0) wdata_o <= load_val;
        default: ;
      endcase
    end
  end

  assign lsu_ready_o   = (state_q == IDLE);
  assign lsu_valid_o   = (state_q == RESP);
  assign mem.mem_req   = (state_q == ADDR);
  assign mem.mem_we    = we_q;
  assign mem.mem_addr  = addr_q;
  assign mem.mem_wdata = mwdata_q;
  assign mem.mem_wstrb = strb_q;
endmodule

// File: tb/tb_ysyx_22041211_lsu.sv
// tb/tb_ysyx_22041211_lsu.sv - randomized self-checking bench for ysyx_22041211_lsu
module tb_ysyx_22041211_lsu;
  localparam logic [2:0] LB = 3'd1, LH = 3'd2, LW = 3'd3, LBU = 3'd4, LHU = 3'd5;
  localparam logic [1:0] SB = 2'd1, SH = 2'd2, SW = 2'd3;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic        rst = 1'b1;
  logic        exu_valid = 1'b0, lsu_ready, lsu_valid, wb_ready = 1'b1;
  logic [2:0]  load_type = 3'd0;
  logic [1:0]  store_type = 2'd0;
  logic [31:0] alu_result = 32'd0, store_data = 32'd0, csr_wdata = 32'd0;
  logic        wd = 1'b0, wd_o, misalign_o;
  logic [4:0]  wreg = 5'd0, wreg_o;
  logic [31:0] wdata_o, csr_wdata_o;

  ysyx_22041211_lsu_if bus();

  ysyx_22041211_lsu #(.DATA_LEN(32)) dut (
    .clk(clk), .rst(rst),
    .exu_valid_i(exu_valid), .lsu_ready_o(lsu_ready),
    .load_type_i(load_type), .store_type_i(store_type),
    .alu_result_i(alu_result), .store_data_i(store_data),
    .wd_i(wd), .wreg_i(wreg), .csr_wdata_i(csr_wdata),
    .mem(bus),
    .lsu_valid_o(lsu_valid), .wb_ready_i(wb_ready),
    .wd_o(wd_o), .wreg_o(wreg_o), .wdata_o(wdata_o),
    .csr_wdata_o(csr_wdata_o), .misalign_o(misalign_o)
  );

  int n_cmp = 0, n_bad = 0;

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got %h want %h", nm, act, exp);
    end
  endtask

  // Memory slave: grant after gnt_wait stall cycles, respond rv_wait cycles after grant.
  // A reset while a response is pending still produces a late rvalid afterwards.
  int gnt_wait = 0, rv_wait = 0, sl = 0, scnt = 0, late = 0;
  logic [31:0] rd_word = 32'd0;
  initial begin
    bus.mem_gnt = 1'b0; bus.mem_rvalid = 1'b0; bus.mem_rdata = 32'd0;
    forever begin
      @(posedge clk); #2;
      bus.mem_gnt = 1'b0; bus.mem_rvalid = 1'b0; bus.mem_rdata = $urandom;
      if (rst) begin
        if (sl == 2) late = 3;
        sl = 0; scnt = 0;
      end else if (late > 0) begin
        late--;
        if (late == 0) bus.mem_rvalid = 1'b1;
      end else if (sl == 0 && bus.mem_req) begin
        if (scnt >= gnt_wait) begin bus.mem_gnt = 1'b1; sl = 2; scnt = 0; end
        else scnt++;
      end else if (sl == 2) begin
        if (scnt >= rv_wait) begin bus.mem_rvalid = 1'b1; bus.mem_rdata = rd_word; sl = 0; scnt = 0; end
        else scnt++;
      end
    end
  end

  // Expected values of the operation in flight.
  logic        chk_en = 1'b0;
  logic        e_bus, e_we, e_wd, e_mis, e_chk_wdata;
  logic [31:0] e_addr, e_mw, e_wdata, e_csr;
  logic [3:0]  e_strb;
  logic [4:0]  e_wreg;

  always @(negedge clk) begin
    if (!rst && chk_en) begin
      if (bus.mem_req) begin
        chk("req_expected", 32'(e_bus), 32'd1);
        chk("mem_addr", bus.mem_addr, e_addr);
        chk("mem_we", 32'(bus.mem_we), 32'(e_we));
        chk("mem_wstrb", 32'(bus.mem_wstrb), 32'(e_strb));
        if (e_we) chk("mem_wdata", bus.mem_wdata, e_mw);
        chk("ready_in_addr", 32'(lsu_ready), 32'd0);
      end
      if (lsu_valid) begin
        chk("wd_o", 32'(wd_o), 32'(e_wd));
        chk("wreg_o", 32'(wreg_o), 32'(e_wreg));
        chk("csr_wdata_o", csr_wdata_o, e_csr);
        chk("misalign_o", 32'(misalign_o), 32'(e_mis));
        if (e_chk_wdata) chk("wdata_o", wdata_o, e_wdata);
        chk("ready_in_resp", 32'(lsu_ready), 32'd0);
      end
    end
  end

  logic        seen_req, seen_mis, seen_wd;
  logic [31:0] seen_addr, seen_mw, seen_wdata;
  logic [3:0]  seen_strb;

  task automatic run_op(input logic [2:0] lt, input logic [1:0] st, input logic [31:0] addr,
                        input logic [31:0] sd, input logic [31:0] rd, input logic wdv,
                        input logic [4:0] wrv, input int gw, input int rw, input int wbw);
    int sz, off, cyc, exp_lat;
    bit sgn, is_ld, is_st;
    logic [31:0] word, mask;
    is_ld = (lt != 0);
    is_st = !is_ld && (st != 0);
    sgn   = (lt == LB) || (lt == LH);
    if (is_ld) sz = (lt == LB || lt == LBU) ? 1 : (lt == LH || lt == LHU) ? 2 : 4;
    else       sz = (st == SB) ? 1 : (st == SH) ? 2 : 4;
    off    = int'(addr[1:0]);
    e_mis  = (is_ld || is_st) && (off % sz != 0);
    e_bus  = (is_ld || is_st) && !e_mis;
    e_addr = addr & 32'hFFFF_FFFC;
    e_we   = is_st;
    e_strb = is_st ? 4'(((1 << sz) - 1) << off) : 4'd0;
    for (int i = 0; i < 4; i++) e_mw[8*i +: 8] = sd[8*(i % sz) +: 8];
    word = rd >> (8 * off);
    mask = (sz == 4) ? 32'hFFFF_FFFF : ((32'd1 << (8 * sz)) - 32'd1);
    if (is_ld) begin
      e_wdata = word & mask;
      if (sgn && word[8*sz-1]) e_wdata = e_wdata | ~mask;
    end else if (is_st) e_wdata = 32'd0;
    else e_wdata = addr;
    e_chk_wdata = !e_mis;
    e_wd   = wdv && !e_mis;
    e_wreg = wrv;
    e_csr  = $urandom;
    exp_lat = e_bus ? 3 + gw + rw : 1;

    gnt_wait = gw; rv_wait = rw; rd_word = rd;
    wb_ready = (wbw == 0);
    load_type = lt; store_type = st; alu_result = addr; store_data = sd;
    wd = wdv; wreg = wrv; csr_wdata = e_csr;
    chk("ready_idle", 32'(lsu_ready), 32'd1);
    exu_valid = 1'b1;
    @(posedge clk); #1;
    exu_valid = 1'b0;
    load_type = 3'($urandom); store_type = 2'($urandom); alu_result = $urandom;
    store_data = $urandom; wd = 1'($urandom); wreg = 5'($urandom); csr_wdata = $urandom;
    seen_req = 1'b0; seen_addr = 32'd0; seen_mw = 32'd0; seen_strb = 4'd0;
    cyc = 1;
    while (!lsu_valid && cyc < 60) begin
      if (bus.mem_req) begin
        seen_req = 1'b1; seen_addr = bus.mem_addr; seen_mw = bus.mem_wdata; seen_strb = bus.mem_wstrb;
      end
      @(posedge clk); #1;
      cyc++;
    end
    chk("latency", 32'(cyc), 32'(exp_lat));
    seen_wdata = wdata_o; seen_mis = misalign_o; seen_wd = wd_o;
    if (lsu_valid) begin
      repeat (wbw) begin @(posedge clk); #1; end
      wb_ready = 1'b1;
      @(posedge clk); #1;
      chk("valid_drop", 32'(lsu_valid), 32'd0);
    end
  endtask

  initial begin
    repeat (3) @(posedge clk);
    #1;
    chk("rst_ctrl", {26'd0, lsu_valid, bus.mem_req, bus.mem_we, wd_o, misalign_o, lsu_ready}, 32'd1);
    chk("rst_strb_wreg", {23'd0, bus.mem_wstrb, wreg_o}, 32'd0);
    chk("rst_wdata", wdata_o, 32'd0);
    chk("rst_csr", csr_wdata_o, 32'd0);
    chk("rst_addr", bus.mem_addr, 32'd0);
    chk("rst_mwdata", bus.mem_wdata, 32'd0);
    rst = 1'b0;
    chk_en = 1'b1;

    run_op(3'd0, 2'd0, 32'h0000_1234, 32'd0, 32'd0, 1'b1, 5'd5, 0, 0, 0);
    chk("t_nonmem_wdata", seen_wdata, 32'h0000_1234);
    chk("t_nonmem_wd", 32'(seen_wd), 32'd1);

    run_op(LB, 2'd0, 32'h8000_0003, 32'd0, 32'h80FF_0000, 1'b1, 5'd7, 0, 0, 0);
    chk("t_lb_addr", seen_addr, 32'h8000_0000);
    chk("t_lb_strb", 32'(seen_strb), 32'd0);
    chk("t_lb_wdata", seen_wdata, 32'hFFFF_FF80);

    run_op(2'd0 == 2'd0 ? 3'd0 : 3'd0, SH, 32'h8000_0002, 32'h0000_ABCD, 32'd0, 1'b0, 5'd3, 0, 0, 0);
    chk("t_sh_strb", 32'(seen_strb), 32'hC);
    chk("t_sh_mwdata", seen_mw, 32'hABCD_ABCD);
    chk("t_sh_wdata", seen_wdata, 32'd0);

    run_op(LW, 2'd0, 32'h8000_0006, 32'd0, 32'd0, 1'b1, 5'd9, 0, 0, 0);
    chk("t_lw_mis_req", 32'(seen_req), 32'd0);
    chk("t_lw_mis_flag", 32'(seen_mis), 32'd1);
    chk("t_lw_mis_wd", 32'(seen_wd), 32'd0);

    run_op(LHU, 2'd0, 32'h8000_000A, 32'd0, 32'h8765_4321, 1'b1, 5'd1, 3, 1, 2);
    chk("t_stall_wdata", seen_wdata, 32'h0000_8765);

    run_op(LBU, SW, 32'h8000_0001, 32'h1111_2222, 32'h0000_F100, 1'b1, 5'd2, 0, 0, 0);
    chk("t_loadwins_we", 32'(seen_strb), 32'd0);
    chk("t_loadwins_wdata", seen_wdata, 32'h0000_00F1);

    // Reset while waiting in DATA; the slave's late rvalid must be ignored.
    chk_en = 1'b0;
    gnt_wait = 0; rv_wait = 20; wb_ready = 1'b1;
    load_type = LW; store_type = 2'd0; alu_result = 32'h8000_0010; exu_valid = 1'b1;
    @(posedge clk); #1;
    exu_valid = 1'b0;
    @(posedge clk); #1;
    rst = 1'b1;
    @(posedge clk); #1;
    rst = 1'b0;
    for (int i = 0; i < 6; i++) begin
      chk("rst_mid_idle", {29'd0, lsu_valid, bus.mem_req, lsu_ready}, 32'd1);
      @(posedge clk); #1;
    end
    chk("rst_mid_outs", {26'd0, wd_o, misalign_o, bus.mem_wstrb}, 32'd0);
    chk("rst_mid_wdata", wdata_o, 32'd0);
    chk_en = 1'b1;

    for (int n = 0; n < 300; n++) begin
      logic [2:0] lt;
      logic [1:0] st;
      lt = ($urandom_range(0, 3) == 0) ? 3'd0 : 3'($urandom_range(1, 5));
      st = 2'($urandom);
      if ($urandom_range(0, 2) != 0 && lt != 0) st = 2'd0;
      run_op(lt, st, 32'h8000_0000 | ($urandom & 32'h0000_FFFF), $urandom, $urandom,
             1'($urandom), 5'($urandom), $urandom_range(0, 3), $urandom_range(0, 3),
             $urandom_range(0, 2));
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end
endmodule
